// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART command sequencer.
package uart_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_GUARD, TX_WAIT} tx_state_t;

    // Bits needed to hold the values 0 .. n-1 (never less than one).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_resp_sender.sv
// Serialises a multi-byte response word through the UART transmitter, MSB byte first.
module uart_resp_sender
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned RESP_BYTES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RESP_BYTES*BYTE_W-1:0] resp,
    input  logic                         send_resp,
    input  logic                         tx_done,
    output logic [BYTE_W-1:0]            tx_data,
    output logic                         trmt,
    output logic                         resp_busy,
    output logic                         resp_done
);

    localparam int unsigned      RESP_W    = RESP_BYTES * BYTE_W;
    localparam int unsigned      BC_W      = cnt_w(RESP_BYTES);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(RESP_BYTES - 1);

    tx_state_t           state_q;
    logic [RESP_W-1:0]   shreg_q;
    logic [BC_W-1:0]     bcnt_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                trmt_q;
    logic                busy_q;
    logic                done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            shreg_q   <= '0;
            bcnt_q    <= '0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            trmt_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        shreg_q <= resp;
                        busy_q  <= 1'b1;
                        bcnt_q  <= '0;
                        state_q <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx_data_q <= shreg_q[RESP_W-1 -: BYTE_W];
                    shreg_q   <= shreg_q << BYTE_W;
                    trmt_q    <= 1'b1;
                    state_q   <= TX_GUARD;
                end
                // tx_done still shows the previous byte's completion here.
                TX_GUARD: state_q <= TX_WAIT;
                TX_WAIT: begin
                    if (tx_done) begin
                        if (bcnt_q == LAST_BYTE) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= TX_IDLE;
                        end else begin
                            bcnt_q  <= bcnt_q + BC_W'(1);
                            state_q <= TX_LOAD;
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_busy = busy_q;
    assign resp_done = done_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Sequencer between the UART byte pair and the command processor: RX frame
// assembly with inter-byte timeout inline, response serialisation in a sub-block.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CMD_BYTES   = 3,
    parameter int unsigned RESP_BYTES  = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BYTE_W-1:0]           rx_data,
    input  logic                        rx_rdy,
    output logic                        clr_rdy,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        trmt,
    input  logic                        tx_done,
    output logic [CMD_BYTES*BYTE_W-1:0] cmd,
    output logic                        cmd_rdy,
    input  logic                        clr_cmd_rdy,
    output logic                        cmd_ovr,
    output logic                        frame_err,
    input  logic [RESP_BYTES*BYTE_W-1:0] resp,
    input  logic                        send_resp,
    output logic                        resp_busy,
    output logic                        resp_done
);

    localparam int unsigned     CMD_W     = CMD_BYTES * BYTE_W;
    localparam int unsigned     BC_W      = cnt_w(CMD_BYTES);
    localparam int unsigned     TC_W      = cnt_w(TIMEOUT_CYC + 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(CMD_BYTES - 1);
    localparam logic [TC_W-1:0] TC_LIMIT  = TC_W'(TIMEOUT_CYC);
    localparam bit              TO_EN     = (TIMEOUT_CYC != 0);

    logic [CMD_W-1:0] asm_q;
    logic [CMD_W-1:0] asm_d;
    logic [CMD_W-1:0] cmd_q;
    logic [BC_W-1:0]  bcnt_q;
    logic [TC_W-1:0]  tcnt_q;
    logic             clr_rdy_q;
    logic             cmd_rdy_q;
    logic             cmd_ovr_q;
    logic             frame_err_q;
    logic             capture;
    logic             frame_done;
    logic             timeout;

    // clr_rdy gating stops a second capture while the receiver is still dropping rdy.
    always_comb begin
        capture    = rx_rdy & ~clr_rdy_q;
        asm_d      = (asm_q << BYTE_W) | CMD_W'(rx_data);
        frame_done = capture && (bcnt_q == LAST_BYTE);
        timeout    = TO_EN && !capture && (bcnt_q != '0) && (tcnt_q == TC_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q       <= '0;
            cmd_q       <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            clr_rdy_q   <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            cmd_ovr_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clr_rdy_q   <= capture;
            cmd_ovr_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (capture) begin
                asm_q  <= asm_d;
                tcnt_q <= '0;
                if (frame_done) begin
                    bcnt_q    <= '0;
                    cmd_q     <= asm_d;
                    cmd_rdy_q <= 1'b1;
                    cmd_ovr_q <= cmd_rdy_q & ~clr_cmd_rdy;
                end else begin
                    bcnt_q <= bcnt_q + BC_W'(1);
                end
            end else if (timeout) begin
                bcnt_q      <= '0;
                tcnt_q      <= '0;
                frame_err_q <= 1'b1;
            end else if (TO_EN && (bcnt_q != '0)) begin
                tcnt_q <= tcnt_q + TC_W'(1);
            end
            // A completing frame takes priority over the consumer's acknowledge.
            if (!frame_done && clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
        end
    end

    assign clr_rdy   = clr_rdy_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign cmd_ovr   = cmd_ovr_q;
    assign frame_err = frame_err_q;

    uart_resp_sender #(
        .RESP_BYTES(RESP_BYTES)
    ) u_sender (
        .clk      (clk),
        .rst      (rst),
        .resp     (resp),
        .send_resp(send_resp),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .trmt     (trmt),
        .resp_busy(resp_busy),
        .resp_done(resp_done)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a simple receiver driver and transmitter model.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        cmd_ovr;
    logic        frame_err;
    logic [15:0] resp = '0;
    logic        send_resp = 1'b0;
    logic        resp_busy;
    logic        resp_done;

    int vectors = 0;
    int miscompares = 0;

    int clr_cnt = 0;
    int trmt_cnt = 0;
    int ovr_cnt = 0;
    int done_cnt = 0;
    logic [7:0] tx_log [0:15];

    int tx_cnt;

    uart_cmd_ctrl #(
        .CMD_BYTES  (3),
        .RESP_BYTES (2),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rdy    (clr_rdy),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_ovr    (cmd_ovr),
        .frame_err  (frame_err),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_busy  (resp_busy),
        .resp_done  (resp_done)
    );

    always #5 clk = ~clk;

    // Transmitter: trmt clears tx_done, which rises again 20 clocks later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done <= 1'b1;
            tx_cnt  <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            tx_cnt  <= 20;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (clr_rdy) clr_cnt++;
        if (cmd_ovr) ovr_cnt++;
        if (resp_done) done_cnt++;
        if (trmt) begin
            if (trmt_cnt < 16) tx_log[trmt_cnt] = tx_data;
            trmt_cnt++;
        end
    end

    // late_drop keeps rx_rdy high over the clr_rdy edge, like a registered receiver.
    task automatic send_byte(input logic [7:0] b, input bit late_drop);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        while (!clr_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!clr_rdy) begin
            $display("FAIL clr_rdy_ack byte=%h: clr_rdy=%b required 1 within 50 clks", b, clr_rdy);
            miscompares++;
        end
        if (late_drop) @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic ack_cmd();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b0) begin
            $display("FAIL cmd_rdy_clear: cmd_rdy=%b required 0", cmd_rdy);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd, cmd_rdy, cmd_ovr, frame_err, clr_rdy} !== 28'h0) begin
            $display("FAIL reset_rx: cmd=%h rdy=%b ovr=%b ferr=%b clr=%b required all 0",
                     cmd, cmd_rdy, cmd_ovr, frame_err, clr_rdy);
            miscompares++;
        end
        vectors++;
        if ({tx_data, trmt, resp_busy, resp_done} !== 11'h0) begin
            $display("FAIL reset_tx: tx_data=%h trmt=%b busy=%b done=%b required all 0",
                     tx_data, trmt, resp_busy, resp_done);
            miscompares++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_frame();
        int c0;
        c0 = clr_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        vectors++;
        if (cmd_rdy !== 1'b0) begin
            $display("FAIL rx_partial_rdy: cmd_rdy=%b required 0", cmd_rdy);
            miscompares++;
        end
        send_byte(8'hC3, 1'b0);
        vectors++;
        if (cmd_rdy !== 1'b1 || cmd !== 24'hA55AC3) begin
            $display("FAIL rx_frame: cmd=%h rdy=%b required A55AC3 / 1", cmd, cmd_rdy);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (clr_cnt - c0 != 3) begin
            $display("FAIL rx_clr_pulses: got %0d required 3", clr_cnt - c0);
            miscompares++;
        end
        ack_cmd();
    endtask

    task automatic test_rdy_hold();
        int c0;
        c0 = clr_cnt;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (cmd !== 24'hA1B2C3 || cmd_rdy !== 1'b1) begin
            $display("FAIL hold_frame: cmd=%h rdy=%b required A1B2C3 / 1", cmd, cmd_rdy);
            miscompares++;
        end
        vectors++;
        if (clr_cnt - c0 != 3) begin
            $display("FAIL hold_clr_pulses: got %0d required 3", clr_cnt - c0);
            miscompares++;
        end
        ack_cmd();
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        n = 0;
        while (!frame_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 101) begin
            $display("FAIL timeout_latency: frame_err after %0d clks required 101", n);
            miscompares++;
        end
        vectors++;
        if (cmd !== 24'hA1B2C3 || cmd_rdy !== 1'b0) begin
            $display("FAIL timeout_cmd_kept: cmd=%h rdy=%b required A1B2C3 / 0", cmd, cmd_rdy);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0) begin
            $display("FAIL timeout_pulse_width: frame_err=%b required 0", frame_err);
            miscompares++;
        end
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        vectors++;
        if (cmd !== 24'h334455 || cmd_rdy !== 1'b1) begin
            $display("FAIL timeout_next_frame: cmd=%h rdy=%b required 334455 / 1", cmd, cmd_rdy);
            miscompares++;
        end
        ack_cmd();
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (ovr_cnt - o0 != 1) begin
            $display("FAIL ovr_pulses: got %0d required 1", ovr_cnt - o0);
            miscompares++;
        end
        vectors++;
        if (cmd !== 24'h040506 || cmd_rdy !== 1'b1) begin
            $display("FAIL ovr_cmd: cmd=%h rdy=%b required 040506 / 1", cmd, cmd_rdy);
            miscompares++;
        end
    endtask

    task automatic test_resp();
        int t0;
        int d0;
        int n;
        t0 = trmt_cnt;
        d0 = done_cnt;
        @(negedge clk);
        resp      = 16'hBEEF;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        vectors++;
        if (resp_busy !== 1'b1 || trmt !== 1'b0) begin
            $display("FAIL resp_accept: busy=%b trmt=%b required 1 / 0", resp_busy, trmt);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (trmt !== 1'b1 || tx_data !== 8'hBE) begin
            $display("FAIL resp_first_trmt: trmt=%b tx_data=%h required 1 / BE", trmt, tx_data);
            miscompares++;
        end
        @(negedge clk);
        resp      = 16'h1234;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        n = 0;
        while (!resp_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        vectors++;
        if (!resp_done || resp_busy !== 1'b0) begin
            $display("FAIL resp_done: done=%b busy=%b required 1 / 0", resp_done, resp_busy);
            miscompares++;
        end
        vectors++;
        if (trmt_cnt - t0 != 2 || tx_log[t0] !== 8'hBE || tx_log[t0+1] !== 8'hEF) begin
            $display("FAIL resp_bytes: count=%0d first=%h second=%h required 2 / BE / EF",
                     trmt_cnt - t0, tx_log[t0], tx_log[t0+1]);
            miscompares++;
        end
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (trmt_cnt - t0 != 2 || done_cnt - d0 != 1 || tx_data !== 8'hEF) begin
            $display("FAIL resp_idle_hold: trmt=%0d done=%0d tx_data=%h required 2 / 1 / EF",
                     trmt_cnt - t0, done_cnt - d0, tx_data);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int o0;
        @(negedge clk);
        resp      = 16'hCAFE;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h77, 1'b0);
        vectors++;
        if (clr_rdy !== 1'b1 || resp_busy !== 1'b1 || cmd_rdy !== 1'b1) begin
            $display("FAIL mid_setup: clr=%b busy=%b rdy=%b required 1 / 1 / 1",
                     clr_rdy, resp_busy, cmd_rdy);
            miscompares++;
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd, cmd_rdy, cmd_ovr, frame_err, clr_rdy} !== 28'h0) begin
            $display("FAIL mid_reset_rx: cmd=%h rdy=%b ovr=%b ferr=%b clr=%b required all 0",
                     cmd, cmd_rdy, cmd_ovr, frame_err, clr_rdy);
            miscompares++;
        end
        vectors++;
        if ({tx_data, trmt, resp_busy, resp_done} !== 11'h0) begin
            $display("FAIL mid_reset_tx: tx_data=%h trmt=%b busy=%b done=%b required all 0",
                     tx_data, trmt, resp_busy, resp_done);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        t0 = trmt_cnt;
        o0 = ovr_cnt;
        repeat (2) @(negedge clk);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'h01, 1'b0);
        vectors++;
        if (cmd !== 24'hDEAD01 || cmd_rdy !== 1'b1) begin
            $display("FAIL post_reset_frame: cmd=%h rdy=%b required DEAD01 / 1", cmd, cmd_rdy);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (trmt_cnt != t0 || ovr_cnt != o0 || resp_busy !== 1'b0) begin
            $display("FAIL post_reset_quiet: trmt=%0d ovr=%0d busy=%b required 0 / 0 / 0",
                     trmt_cnt - t0, ovr_cnt - o0, resp_busy);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_rx_frame();
        test_rdy_hold();
        test_timeout();
        test_overrun();
        test_resp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
